// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: FSM encodings, byte width and
// the ACK/NACK levels used by the receive front end and address unit.
package i2c_pkg;

  localparam int I2C_BYTE_BITS = 8;

  localparam logic I2C_ACK  = 1'b1;
  localparam logic I2C_NACK = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX_BITS   = 3'd1,
    ST_ACK_SETUP = 3'd2,
    ST_ACK_DRIVE = 3'd3,
    ST_IGNORE    = 3'd4
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Raw I2C line synchroniser with edge strobes; define
// I2C_RX_GLITCH_FILTER_EN to add a FILTER_LEN-sample stability filter.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

`ifdef I2C_RX_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  // Idle bus level is high, so reset to 1 to avoid fake edges
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], line};
  end

  if (FILT_EN && FILTER_LEN > 1) begin : g_filt
    logic [FILTER_LEN-2:0] hist;
    logic [FILTER_LEN-1:0] win;
    logic                  filt_q;

    assign win = {hist, sync_q[SYNC_STAGES-1]};

    always_ff @(posedge clk) begin
      if (rst) begin
        hist   <= '1;
        filt_q <= 1'b1;
      end else begin
        hist <= win[FILTER_LEN-2:0];
        if (&win)       filt_q <= 1'b1;
        else if (~|win) filt_q <= 1'b0;
      end
    end

    assign level = filt_q;
  end else begin : g_raw
    assign level = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/i2c_slave_byte_rx.sv
// I2C slave bus front end: START/STOP detect, byte shift-in, ACK drive.
// Optional SCL/SDA glitch filter enabled by I2C_RX_GLITCH_FILTER_EN.
module i2c_slave_byte_rx
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SCL,
  input  logic       SDA,
  input  logic       Ack,
  output logic       SdaOe,
  output logic       Start,
  output logic       Stop,
  output logic       ByteValid,
  output logic [7:0] ByteData,
  output logic       FirstByte,
  output logic       BusBusy
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_det, stop_det;

  state_t                   state;
  logic [3:0]               cnt;
  logic [I2C_BYTE_BITS-2:0] shift;
  logic                     first;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_scl (
    .clk  (Clk),
    .rst  (Rst),
    .line (SCL),
    .level(scl_s),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sda (
    .clk  (Clk),
    .rst  (Rst),
    .line (SDA),
    .level(sda_s),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  // SCL high now and not just risen means it was high last cycle too
  assign start_det = sda_fall & scl_s & ~scl_rise;
  assign stop_det  = sda_rise & scl_s & ~scl_rise;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shift     <= '0;
      first     <= 1'b0;
      SdaOe     <= 1'b0;
      Start     <= 1'b0;
      Stop      <= 1'b0;
      ByteValid <= 1'b0;
      ByteData  <= '0;
      FirstByte <= 1'b0;
      BusBusy   <= 1'b0;
    end else begin
      Start     <= 1'b0;
      Stop      <= 1'b0;
      ByteValid <= 1'b0;
      FirstByte <= 1'b0;
      if (start_det) begin
        Start   <= 1'b1;
        BusBusy <= 1'b1;
        SdaOe   <= 1'b0;
        cnt     <= '0;
        first   <= 1'b1;
        state   <= ST_RX_BITS;
      end else if (stop_det) begin
        Stop    <= 1'b1;
        BusBusy <= 1'b0;
        SdaOe   <= 1'b0;
        cnt     <= '0;
        state   <= ST_IDLE;
      end else begin
        unique case (state)
          ST_RX_BITS: begin
            if (scl_rise) begin
              shift <= {shift[I2C_BYTE_BITS-3:0], sda_s};
              if (cnt == 4'(I2C_BYTE_BITS - 1)) begin
                ByteData  <= {shift, sda_s};
                ByteValid <= 1'b1;
                FirstByte <= first;
                first     <= 1'b0;
                cnt       <= '0;
                state     <= ST_ACK_SETUP;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          ST_ACK_SETUP: begin
            if (scl_fall) begin
              if (Ack == I2C_ACK) begin
                SdaOe <= 1'b1;
                state <= ST_ACK_DRIVE;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          ST_ACK_DRIVE: begin
            if (scl_fall) begin
              SdaOe <= 1'b0;
              state <= ST_RX_BITS;
            end
          end
          ST_IDLE, ST_IGNORE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_byte_rx.sv
// Directed bench for i2c_slave_byte_rx with an open-drain SDA model
// and a byte scoreboard; glitch expectations follow I2C_RX_GLITCH_FILTER_EN.
module tb_i2c_slave_byte_rx;

  localparam int H = 10;
  localparam int Q = 5;

  typedef struct packed {
    logic [7:0] data;
    logic       first;
  } byte_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       SCL = 1'b1;
  logic       sda_m = 1'b1;
  logic       Ack = 1'b1;
  logic       SDA;
  logic       SdaOe, Start, Stop, ByteValid, FirstByte, BusBusy;
  logic [7:0] ByteData;

  assign SDA = sda_m & ~SdaOe;

  i2c_slave_byte_rx #(
    .SYNC_STAGES(2),
    .FILTER_LEN (3)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .SCL      (SCL),
    .SDA      (SDA),
    .Ack      (Ack),
    .SdaOe    (SdaOe),
    .Start    (Start),
    .Stop     (Stop),
    .ByteValid(ByteValid),
    .ByteData (ByteData),
    .FirstByte(FirstByte),
    .BusBusy  (BusBusy)
  );

  always #5 Clk = ~Clk;

  int    checks = 0;
  int    errors = 0;
  byte_t exp_q[$];
  byte_t got[64];
  int    got_n = 0;
  int    rd = 0;
  int    start_cnt = 0, stop_cnt = 0;
  int    oe_cnt = 0, idle_cnt = 0;
  int    s0, p0, o0, i0;
  logic  ack_low, oe_all;

  always @(negedge Clk) begin
    if (ByteValid && got_n < 64) begin
      got[got_n] = {ByteData, FirstByte};
      got_n++;
    end
    if (Start) start_cnt++;
    if (Stop) stop_cnt++;
    if (SdaOe) oe_cnt++;
    if (!BusBusy) idle_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic snap();
    s0 = start_cnt;
    p0 = stop_cnt;
    o0 = oe_cnt;
    i0 = idle_cnt;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    clks(Q);
    SCL = 1'b1;
    clks(H);
    sda_m = 1'b0;
    clks(H);
    SCL = 1'b0;
    clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    clks(Q);
    SCL = 1'b1;
    clks(H);
    sda_m = 1'b1;
    clks(H);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    clks(Q);
    SCL = 1'b1;
    clks(H);
    SCL = 1'b0;
    clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic ack_slot(output logic low, output logic oe);
    sda_m = 1'b1;
    clks(Q);
    SCL = 1'b1;
    low = 1'b1;
    oe  = 1'b1;
    repeat (H) begin
      clks(1);
      low &= ~SDA;
      oe  &= SdaOe;
    end
    SCL = 1'b0;
    clks(Q);
  endtask

  task automatic drain(input string tag);
    byte_t e, g;
    check({tag, "_nbytes"}, got_n - rd, exp_q.size());
    while (exp_q.size() > 0 && rd < got_n) begin
      e = exp_q.pop_front();
      g = got[rd];
      rd++;
      check({tag, "_data"}, g.data, e.data);
      check({tag, "_first"}, g.first, e.first);
    end
    exp_q.delete();
    rd = got_n;
  endtask

  initial begin
    clks(3);
    check("rst_sdaoe", SdaOe, 0);
    check("rst_start", Start, 0);
    check("rst_stop", Stop, 0);
    check("rst_valid", ByteValid, 0);
    check("rst_data", ByteData, 8'h00);
    check("rst_first", FirstByte, 0);
    check("rst_busy", BusBusy, 0);
    Rst = 1'b0;
    clks(20);

    // reset in the middle of a byte
    snap();
    i2c_start();
    check("mid_busy", BusBusy, 1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    Rst = 1'b1;
    clks(1);
    check("mid_rst_busy", BusBusy, 0);
    check("mid_rst_sdaoe", SdaOe, 0);
    clks(2);
    Rst = 1'b0;
    clks(1);
    check("mid_after_busy", BusBusy, 0);
    check("mid_after_start", Start, 0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ack_slot(ack_low, oe_all);
    check("mid_no_oe", oe_cnt - o0, 0);
    i2c_stop();
    clks(10);
    drain("mid");

    // address byte with ACK
    Ack = 1'b1;
    snap();
    exp_q.push_back('{8'hA4, 1'b1});
    i2c_start();
    check("addr_busy", BusBusy, 1);
    send_byte(8'hA4);
    ack_slot(ack_low, oe_all);
    check("addr_ack_low", ack_low, 1);
    check("addr_oe_9th", oe_all, 1);
    i2c_stop();
    clks(5);
    check("addr_start", start_cnt - s0, 1);
    check("addr_stop", stop_cnt - p0, 1);
    check("addr_busy_end", BusBusy, 0);
    check("addr_oe_end", SdaOe, 0);
    drain("addr");

    // two-byte write
    snap();
    exp_q.push_back('{8'h50, 1'b1});
    i2c_start();
    send_byte(8'h50);
    ack_slot(ack_low, oe_all);
    check("wr_ack0", ack_low, 1);
    exp_q.push_back('{8'h3C, 1'b0});
    send_byte(8'h3C);
    ack_slot(ack_low, oe_all);
    check("wr_ack1", ack_low, 1);
    i2c_stop();
    clks(5);
    drain("wr");
    check("wr_data_held", ByteData, 8'h3C);
    check("wr_stop", stop_cnt - p0, 1);

    // NACK then ignored byte
    Ack = 1'b0;
    snap();
    exp_q.push_back('{8'h22, 1'b1});
    i2c_start();
    send_byte(8'h22);
    ack_slot(ack_low, oe_all);
    check("nack_sda_high", ack_low, 0);
    send_byte(8'hFF);
    ack_slot(ack_low, oe_all);
    check("nack_oe_never", oe_cnt - o0, 0);
    drain("nack");
    i2c_stop();
    clks(5);
    check("nack_stop", stop_cnt - p0, 1);
    Ack = 1'b1;

    // repeated START mid-byte
    snap();
    i2c_start();
    i0 = idle_cnt;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    i2c_start();
    exp_q.push_back('{8'hA5, 1'b1});
    send_byte(8'hA5);
    ack_slot(ack_low, oe_all);
    check("rs_busy_held", idle_cnt - i0, 0);
    check("rs_starts", start_cnt - s0, 2);
    i2c_stop();
    clks(5);
    drain("rs");

    // 2-Clk SDA spike while SCL is high
    snap();
    clks(10);
    sda_m = 1'b0;
    clks(2);
    sda_m = 1'b1;
    clks(30);
`ifdef I2C_RX_GLITCH_FILTER_EN
    check("glitch_start", start_cnt - s0, 0);
    check("glitch_stop", stop_cnt - p0, 0);
`else
    check("glitch_start", start_cnt - s0, 1);
    check("glitch_stop", stop_cnt - p0, 1);
`endif
    check("glitch_busy", BusBusy, 0);
    drain("glitch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_byte_rx.md
Name: i2c_slave_byte_rx

Overview:
- Bus-side front end of the I2C slave. It sits directly upstream of the slave address/control unit.
- Synchronises raw SCL/SDA to the system clock and detects START, repeated START and STOP.
- Shifts in bytes MSB-first and hands each completed byte downstream with a one-cycle valid pulse.
- Drives the ACK/NACK bit on SDA as decided by the downstream unit.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each SCL/SDA input synchroniser (minimum 2).
- FILTER_LEN, 3, consecutive equal synchronised samples required before a line change is accepted (glitch filter only).

Ports:
- Clk  input  1  system clock; must run at least 8x the SCL frequency.
- Rst  input  1  synchronous reset, active-high.
- SCL  input  1  raw I2C clock line.
- SDA  input  1  raw I2C data line (input path of the open-drain pad).
- Ack  input  1  downstream decision for the current byte: 1 = ACK, 0 = NACK. Sampled as defined below.
- SdaOe  output  1  1 = pull SDA low. Pad logic handles the open-drain output.
- Start  output  1  one-cycle pulse on START or repeated START.
- Stop  output  1  one-cycle pulse on STOP.
- ByteValid  output  1  one-cycle pulse: ByteData holds a complete byte.
- ByteData  output  8  last received byte, MSB first on the wire; held until the next byte completes.
- FirstByte  output  1  qualifies ByteValid: 1 = first byte after a START (address + R/W bit in bit 0).
- BusBusy  output  1  level: high between START and STOP.

Behaviour:
- Reset: on a Clk edge with Rst=1, every output goes to 0, ByteData to 8'h00, the FSM to IDLE, and the bit counter to 0. Reset aborts any transfer, including a driven ACK; SdaOe is 0 from the next cycle.
- Input path: each line passes through SYNC_STAGES flops, then the optional filter. scl_s/sda_s denote the resulting levels. scl_rise/scl_fall are single-cycle edge strobes from scl_s versus its previous value.
- START condition: sda_s falls while scl_s is high in both the current and previous cycle. Effect:
  - Start pulses the following cycle and BusBusy is set.
  - Bit counter clears, the first-byte flag is set, and the FSM enters RX_BITS.
  - This applies from any state, so a repeated START mid-byte or during ACK aborts the byte with no ByteValid.
- STOP condition: sda_s rises while scl_s is high in both cycles. Effect:
  - Stop pulses the following cycle and BusBusy clears.
  - SdaOe is released and the FSM enters IDLE.
  - A partial byte is discarded.
- START/STOP have priority over any bit action in the same cycle.
- FSM states: IDLE, RX_BITS, ACK_SETUP, ACK_DRIVE, IGNORE.
  - IDLE: only START/STOP detection is active; SCL edges are ignored.
  - RX_BITS, on scl_rise: ByteData-shift <= {shift[6:0], sda_s}; counter +1. When the counter reaches 8:
    - ByteData is loaded and ByteValid pulses on the next cycle.
    - FirstByte equals the first-byte flag in that cycle; the flag then clears.
    - The FSM goes to ACK_SETUP and the counter clears.
  - ACK_SETUP: on scl_fall, Ack is sampled. Ack=1: SdaOe=1, go to ACK_DRIVE. Ack=0: SdaOe stays 0, go to IGNORE.
  - ACK_DRIVE: SdaOe held through the 9th SCL pulse; on scl_fall, SdaOe=0 and the FSM returns to RX_BITS.
  - IGNORE: NACKed or not addressed. No shifting and no ByteValid until START or STOP.
- Latency:
  - Start/Stop/ByteValid fire one Clk after the internal detection cycle.
  - The pin-to-detection delay is SYNC_STAGES (+FILTER_LEN with the filter) Clk cycles.
- Ack must be stable from ByteValid until the next scl_fall; the downstream unit has at least half an SCL period to decide.
- Counter width is 4 bits; it never exceeds 8, and there is no wrap.
- SCL/SDA activity while BusBusy=0 and no START has occurred is ignored.

Optional Feature:
- Macro: I2C_RX_GLITCH_FILTER_EN.
- Defined: each synchronised line passes through a FILTER_LEN-sample stability filter. The accepted level changes only after FILTER_LEN consecutive equal samples, which suppresses spikes shorter than FILTER_LEN Clk.
- Undefined: the synchronised lines are used directly, FILTER_LEN is unused, and detection latency is SYNC_STAGES.

Decomposition:
- Shared package i2c_pkg:
  - FSM state encodings (3-bit).
  - I2C_BYTE_BITS = 8.
  - ACK/NACK level constants, shared with the address unit.
- One sub-module, i2c_line_sync: synchroniser + optional filter + rise/fall strobes. Instantiated once for SCL and once for SDA.

Test Plan:
- Reset: assert Rst for 3 Clk mid-byte (after 4 bits). Required: all outputs 0 next cycle, SdaOe=0, and no ByteValid for the partial byte.
- Address byte: START, send 8'hA4, Ack=1, STOP. Required: Start pulse; ByteValid with ByteData=8'hA4 and FirstByte=1; SdaOe=1 across the 9th SCL pulse; Stop pulse; BusBusy 1 then 0.
- Two-byte write: START, 8'h50 (Ack=1), 8'h3C (Ack=1), STOP. Required: two ByteValid pulses, with FirstByte 1 then 0 and data 8'h50 then 8'h3C.
- NACK/ignore: START, 8'h22 with Ack=0, followed by 8'hFF. Required: SdaOe never 1, exactly one ByteValid (8'h22), and nothing further until STOP.
- Repeated START mid-byte: START, 5 bits, repeated START, 8'hA5. Required: two Start pulses, one ByteValid (8'hA5, FirstByte=1), and BusBusy high throughout.
- Glitch (macro defined, FILTER_LEN=3): 2-Clk low spike on SDA while SCL is high. Required: no Start/Stop. Same stimulus with the macro undefined: Start pulse.
